// File: rtl/mem_request_splitter_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_request_splitter_multi                                      |
// | Purpose  : Splits one (address, size) request into sub-requests that never |
// |            cross a 2^BOUNDARY_LOG2 boundary nor exceed 2^MAX_CHUNK_LOG2.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_request_splitter_multi #(
    parameter int ADDR_WIDTH     = 64,
    parameter int REQ_SIZE_WIDTH = 16,
    parameter int BOUNDARY_LOG2  = 12,
    parameter int MAX_CHUNK_LOG2 = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [REQ_SIZE_WIDTH-1:0] in_size,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [REQ_SIZE_WIDTH-1:0] out_size,
    output logic                      out_first,
    output logic                      out_last,
    output logic [REQ_SIZE_WIDTH-1:0] out_chunk_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int c_cw = (REQ_SIZE_WIDTH > BOUNDARY_LOG2 + 1) ? REQ_SIZE_WIDTH : BOUNDARY_LOG2 + 1;
    localparam logic [c_cw-1:0] c_bnd_span = c_cw'(1) << BOUNDARY_LOG2;

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_emit = 1'b1;

    generate
        if (MAX_CHUNK_LOG2 < 0 || MAX_CHUNK_LOG2 > BOUNDARY_LOG2) begin : g_bad_max_chunk
            $error("MAX_CHUNK_LOG2 must lie in 0..BOUNDARY_LOG2");
        end
    endgenerate

    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_out_addr;
    logic [REQ_SIZE_WIDTH-1:0] r_out_size;
    logic [REQ_SIZE_WIDTH-1:0] r_out_chunk_idx;
    logic [REQ_SIZE_WIDTH-1:0] r_rem;
    logic                      r_out_valid;
    logic                      r_out_first;
    logic                      r_out_last;
    logic                      r_done;

    logic [ADDR_WIDTH-1:0]     w_src_addr;
    logic [REQ_SIZE_WIDTH-1:0] w_src_rem;
    logic [REQ_SIZE_WIDTH-1:0] w_idx_nxt;
    logic [c_cw-1:0]           w_to_bnd;
    logic [c_cw-1:0]           w_to_max;
    logic [c_cw-1:0]           w_rem_ext;
    logic [c_cw-1:0]           w_chunk;
    logic                      w_load;
    logic                      w_valid_nxt;
    logic                      w_done_nxt;

    // r_rem counts the bytes still owed including the chunk currently presented,
    // so the next chunk's source is simply the presented chunk advanced by its size.
    assign w_src_addr = (r_state == c_idle) ? in_addr : r_out_addr + ADDR_WIDTH'(r_out_size);
    assign w_src_rem  = (r_state == c_idle) ? in_size : r_rem - r_out_size;
    assign w_idx_nxt  = (r_state == c_idle) ? '0 : r_out_chunk_idx + 1'b1;

    assign w_rem_ext = c_cw'(w_src_rem);
    assign w_to_bnd  = c_bnd_span - {{(c_cw - BOUNDARY_LOG2){1'b0}}, w_src_addr[BOUNDARY_LOG2-1:0]};

    generate
        if (MAX_CHUNK_LOG2 == 0) begin : g_max_unit
            assign w_to_max = c_cw'(1);
        end else begin : g_max_grid
            localparam logic [c_cw-1:0] c_max_span = c_cw'(1) << MAX_CHUNK_LOG2;
            assign w_to_max = c_max_span - {{(c_cw - MAX_CHUNK_LOG2){1'b0}}, w_src_addr[MAX_CHUNK_LOG2-1:0]};
        end
    endgenerate

    always_comb begin
        w_chunk = w_rem_ext;
        if (w_to_bnd < w_chunk) w_chunk = w_to_bnd;
        if (w_to_max < w_chunk) w_chunk = w_to_max;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= c_idle;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (in_valid && in_size != '0) w_state_nxt = c_emit;
            c_emit:  if (out_ready && r_out_last)   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        w_load      = 1'b0;
        w_valid_nxt = r_out_valid;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_idle: begin
                w_valid_nxt = 1'b0;
                if (in_valid) begin
                    if (in_size == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            c_emit: begin
                if (out_ready) begin
                    if (r_out_last) begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_valid_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid     <= 1'b0;
            r_out_first     <= 1'b0;
            r_out_last      <= 1'b0;
            r_done          <= 1'b0;
            r_out_addr      <= '0;
            r_out_size      <= '0;
            r_out_chunk_idx <= '0;
            r_rem           <= '0;
        end else begin
            r_out_valid <= w_valid_nxt;
            r_done      <= w_done_nxt;
            if (w_load) begin
                r_out_addr      <= w_src_addr;
                r_out_size      <= w_chunk[REQ_SIZE_WIDTH-1:0];
                r_rem           <= w_src_rem;
                r_out_chunk_idx <= w_idx_nxt;
                r_out_first     <= (w_idx_nxt == '0);
                r_out_last      <= (w_chunk == w_rem_ext);
            end
        end
    end

    assign in_ready      = (r_state == c_idle);
    assign busy          = (r_state == c_emit);
    assign out_valid     = r_out_valid;
    assign out_addr      = r_out_addr;
    assign out_size      = r_out_size;
    assign out_first     = r_out_first;
    assign out_last      = r_out_last;
    assign out_chunk_idx = r_out_chunk_idx;
    assign done          = r_done;

endmodule
`default_nettype wire
